// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for an RV32I subset (R-type, addi, lw, sw, beq).
// Optional performance counters are enabled with `define PERF_COUNTERS_EN.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
`ifdef PERF_COUNTERS_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       trap,
  output logic [3:0] state_dbg
`ifdef PERF_COUNTERS_EN
  , output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam int unsigned TMO_W    = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned TMO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_MEM   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd15
  } state_e;

  state_e           state;
  state_e           state_next;
  logic [TMO_W-1:0] wait_cnt;
  logic [TMO_W-1:0] wait_cnt_next;
  logic             is_store;
  logic             mem_wait;
  logic             timed_out;

  // State register; load/store flavour is captured in DECODE so opcode is not needed later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      is_store <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (state == S_DECODE) begin
        is_store <= (opcode == OP_SW);
      end
    end
  end

  // Next-state logic and memory wait timeout.
  always_comb begin
    state_next    = state;
    wait_cnt_next = '0;
    mem_wait      = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR)) && !mem_ready;
    timed_out     = (MEM_TIMEOUT != 0) && mem_wait && (wait_cnt == TMO_W'(TMO_LAST));

    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:          state_next = S_EXEC_R;
          OP_I:          state_next = S_EXEC_I;
          OP_LW, OP_SW:  state_next = S_MEM_ADDR;
          OP_BEQ:        state_next = S_BRANCH;
          default:       state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_next = is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_next = S_WB_MEM;
      S_WB_MEM:   state_next = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
      S_EXEC_R:   state_next = S_WB_ALU;
      S_EXEC_I:   state_next = S_WB_ALU;
      S_WB_ALU:   state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_TRAP;
    endcase

    if (timed_out) begin
      state_next = S_TRAP;
    end else if (mem_wait) begin
      wait_cnt_next = wait_cnt + TMO_W'(1);
    end
  end

  // Output decode; everything is held at 0 while rst is high.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    trap       = 1'b0;
    state_dbg  = 4'd0;

    if (!rst) begin
      state_dbg = state;
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          alu_src_b = 2'b01;
        end
        S_DECODE:   alu_src_b = 2'b10;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_WB_ALU: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'b01;
          pc_src     = 1'b1;
          pc_write   = zero;
          instr_done = 1'b1;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  // Cycle counter freezes in TRAP; both counters wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_TRAP) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (instr_done) begin
        instret_cnt <= instret_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed sequences plus randomized
// instruction mixes checked against a per-instruction state-sequence model.
module tb_multicycle_control_fsm;

  localparam int unsigned TMO = 4;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEM_ADDR = 4'd2, ST_MEM_RD = 4'd3,
                         ST_WB_MEM = 4'd4, ST_MEM_WR = 4'd5, ST_EXEC_R = 4'd6, ST_EXEC_I = 4'd7,
                         ST_WB_ALU = 4'd8, ST_BRANCH = 4'd9, ST_TRAP = 4'd15;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BEQ = 7'b1100011;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg;
  logic       alu_src_a, instr_done, trap;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state_dbg;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_cnt, instret_cnt;
  logic [31:0] exp_cycles, exp_instret;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;

  logic [6:0] cur_op;
  logic       cur_zero;

  multicycle_control_fsm #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .trap(trap), .state_dbg(state_dbg)
`ifdef PERF_COUNTERS_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, instr_done, trap, state_dbg};

  // Expected output table per state, from the control-signal description.
  function automatic logic [18:0] exp_vec(input logic [3:0] st, input logic rdy, input logic z);
    logic mreq, we, ad, irw, pcw, pcs, rw, m2r, a, done, trp;
    logic [1:0] b, op;
    {mreq, we, ad, irw, pcw, pcs, rw, m2r, a, done, trp} = '0;
    b  = 2'b00;
    op = 2'b00;
    case (st)
      ST_FETCH:    begin mreq = 1'b1; irw = rdy; pcw = rdy; b = 2'b01; end
      ST_DECODE:   b = 2'b10;
      ST_MEM_ADDR: begin a = 1'b1; b = 2'b10; end
      ST_MEM_RD:   begin mreq = 1'b1; ad = 1'b1; end
      ST_WB_MEM:   begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
      ST_MEM_WR:   begin mreq = 1'b1; we = 1'b1; ad = 1'b1; done = rdy; end
      ST_EXEC_R:   begin a = 1'b1; op = 2'b10; end
      ST_EXEC_I:   begin a = 1'b1; b = 2'b10; end
      ST_WB_ALU:   begin rw = 1'b1; done = 1'b1; end
      ST_BRANCH:   begin a = 1'b1; op = 2'b01; pcs = 1'b1; pcw = z; done = 1'b1; end
      ST_TRAP:     trp = 1'b1;
      default:     ;
    endcase
    return {mreq, we, ad, irw, pcw, pcs, rw, m2r, a, b, op, done, trp, st};
  endfunction

  task automatic check_vec(input string tag, input logic [18:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%b required=%b", tag, cyc_no, obs, expv);
    end
  endtask

  // One non-reset cycle expected in state st with mem_ready=rdy.
  task automatic cyc(input logic [3:0] st, input logic rdy);
    logic [18:0] e;
    @(negedge clk);
    rst = 1'b0; mem_ready = rdy; opcode = cur_op; zero = cur_zero;
    #1;
    cyc_no++;
    e = exp_vec(st, rdy, cur_zero);
    check_vec("outputs", e);
`ifdef PERF_COUNTERS_EN
    checks++;
    assert (cycle_cnt === exp_cycles) else begin
      failures++;
      $error("FAIL cycle_cnt cycle=%0d observed=%0d required=%0d", cyc_no, cycle_cnt, exp_cycles);
    end
    checks++;
    assert (instret_cnt === exp_instret) else begin
      failures++;
      $error("FAIL instret_cnt cycle=%0d observed=%0d required=%0d", cyc_no, instret_cnt, exp_instret);
    end
    if (st != ST_TRAP) exp_cycles++;
    if (e[5]) exp_instret++;
`endif
  endtask

  // One reset cycle with random inputs: all outputs must be 0.
  task automatic rst_cyc();
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'($urandom); opcode = 7'($urandom); zero = 1'($urandom);
    #1;
    cyc_no++;
    check_vec("reset_outputs", 19'd0);
`ifdef PERF_COUNTERS_EN
    exp_cycles  = '0;
    exp_instret = '0;
`endif
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected state walk for one instruction, with fd/md wait cycles before ready.
  task automatic run_instr(input int cls, input int fd, input int md, input logic z);
    case (cls)
      C_R:     cur_op = OP_R;
      C_I:     cur_op = OP_I;
      C_LW:    cur_op = OP_LW;
      C_SW:    cur_op = OP_SW;
      default: cur_op = OP_BEQ;
    endcase
    cur_zero = z;
    for (int i = 0; i < fd; i++) cyc(ST_FETCH, 1'b0);
    cyc(ST_FETCH, 1'b1);
    cyc(ST_DECODE, rbit());
    case (cls)
      C_R:  begin cyc(ST_EXEC_R, rbit()); cyc(ST_WB_ALU, rbit()); end
      C_I:  begin cyc(ST_EXEC_I, rbit()); cyc(ST_WB_ALU, rbit()); end
      C_LW: begin
        cyc(ST_MEM_ADDR, rbit());
        for (int i = 0; i < md; i++) cyc(ST_MEM_RD, 1'b0);
        cyc(ST_MEM_RD, 1'b1);
        cyc(ST_WB_MEM, rbit());
      end
      C_SW: begin
        cyc(ST_MEM_ADDR, rbit());
        for (int i = 0; i < md; i++) cyc(ST_MEM_WR, 1'b0);
        cyc(ST_MEM_WR, 1'b1);
      end
      default: cyc(ST_BRANCH, rbit());
    endcase
  endtask

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  initial begin
    logic [6:0] bad;
    rst = 1'b1; mem_ready = 1'b0; opcode = '0; zero = 1'b0;
    cur_op = OP_R; cur_zero = 1'b0;
`ifdef PERF_COUNTERS_EN
    exp_cycles = '0; exp_instret = '0;
`endif

    rst_cyc(); rst_cyc();

    // Back-to-back R-type, then fetch ready on the last allowed wait cycle.
    for (int i = 0; i < 3; i++) run_instr(C_R, 0, 0, 1'b0);
    run_instr(C_R, TMO - 1, 0, 1'b0);
    // lw with three wait cycles in MEM_RD; beq taken and not taken.
    run_instr(C_LW, 0, 3, 1'b0);
    run_instr(C_BEQ, 0, 0, 1'b1);
    run_instr(C_BEQ, 0, 0, 1'b0);
    run_instr(C_SW, 0, TMO - 1, 1'b0);
    run_instr(C_I, 0, 0, 1'b1);

    for (int n = 0; n < 60; n++) begin
      run_instr($urandom_range(0, 4), $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), rbit());
    end

    // FETCH timeout: TMO waiting cycles, then sticky TRAP ignoring mem_ready.
    cur_op = OP_R;
    for (int i = 0; i < TMO; i++) cyc(ST_FETCH, 1'b0);
    for (int i = 0; i < 5; i++) cyc(ST_TRAP, rbit());

    // Illegal opcode traps from DECODE.
    rst_cyc();
    bad = 7'($urandom);
    while (is_legal(bad)) bad = 7'($urandom);
    cur_op = bad;
    cyc(ST_FETCH, 1'b1);
    cyc(ST_DECODE, rbit());
    for (int i = 0; i < 4; i++) cyc(ST_TRAP, rbit());
    rst_cyc();
    cur_op = 7'b1111111;
    cyc(ST_FETCH, 1'b1);
    cyc(ST_DECODE, 1'b0);
    for (int i = 0; i < 3; i++) cyc(ST_TRAP, rbit());

    // Load data-phase timeout.
    rst_cyc();
    cur_op = OP_LW;
    cyc(ST_FETCH, 1'b1);
    cyc(ST_DECODE, 1'b0);
    cyc(ST_MEM_ADDR, 1'b0);
    for (int i = 0; i < TMO; i++) cyc(ST_MEM_RD, 1'b0);
    for (int i = 0; i < 3; i++) cyc(ST_TRAP, rbit());

    // Reset in the middle of a store abandons the request.
    rst_cyc();
    cur_op = OP_SW;
    cyc(ST_FETCH, 1'b1);
    cyc(ST_DECODE, 1'b0);
    cyc(ST_MEM_ADDR, 1'b0);
    cyc(ST_MEM_WR, 1'b0);
    cyc(ST_MEM_WR, 1'b0);
    rst_cyc();
    for (int i = 0; i < 3; i++) run_instr(C_R, 0, 0, 1'b0);
    run_instr(C_SW, 1, 1, 1'b0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
